// File: rtl/data_bus_arbiter_if.sv
// rtl/data_bus_arbiter_if.sv - requester, memory and grant signals of the two-port data bus arbiter
// slave = the arbiter itself; master = the requesters and memory that surround it.
interface data_bus_arbiter_if;
  logic        a_req;
  logic        a_rw;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic [31:0] a_rdata;

  logic        b_req;
  logic        b_rw;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;

  logic        m_strobe;
  logic        m_rw;
  logic [31:0] m_addr;
  logic [31:0] m_dout;
  logic [31:0] m_din;

  logic [1:0]  owner;

  modport slave (
    input  a_req, a_rw, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_rw, b_addr, b_wdata,
    output b_ack, b_rdata,
    output m_strobe, m_rw, m_addr, m_dout,
    input  m_din,
    output owner
  );

  modport master (
    output a_req, a_rw, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_rw, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  m_strobe, m_rw, m_addr, m_dout,
    output m_din,
    input  owner
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-port arbiter serialising requests onto a single-ported memory bus
// Tie-break: DATA_BUS_ARBITER_RR_EN defined = round-robin, undefined = port A fixed priority.
module data_bus_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  data_bus_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] CNT_INIT  = 3'(LATENCY - 1);
  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_A     = 2'b01;
  localparam logic [1:0] OWN_B     = 2'b10;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [1:0]  owner_q;
  logic        rw_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        strobe_q;
  logic        a_ack_q;
  logic        b_ack_q;
  logic [31:0] a_rdata_q;
  logic [31:0] b_rdata_q;

  logic        any_req_d;
  logic        pick_b_d;

  assign any_req_d = bus.a_req | bus.b_req;

`ifdef DATA_BUS_ARBITER_RR_EN
  // last_q = 1 means port B holds the most recent completed grant
  logic last_q;
  assign pick_b_d = bus.b_req & (~bus.a_req | ~last_q);
`else
  assign pick_b_d = bus.b_req & ~bus.a_req;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      owner_q   <= OWN_NONE;
      rw_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      strobe_q  <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= 32'd0;
      b_rdata_q <= 32'd0;
`ifdef DATA_BUS_ARBITER_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      strobe_q <= 1'b0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            // requester inputs are sampled only here; later changes wait for the next grant
            owner_q  <= pick_b_d ? OWN_B : OWN_A;
            rw_q     <= pick_b_d ? bus.b_rw    : bus.a_rw;
            addr_q   <= pick_b_d ? bus.b_addr  : bus.a_addr;
            wdata_q  <= pick_b_d ? bus.b_wdata : bus.a_wdata;
            strobe_q <= 1'b1;
            state_q  <= S_ISSUE;
          end else begin
            owner_q <= OWN_NONE;
          end
        end

        S_ISSUE: begin
          if (rw_q) begin
            a_ack_q <= (owner_q == OWN_A);
            b_ack_q <= (owner_q == OWN_B);
            state_q <= S_DONE;
          end else begin
            cnt_q   <= CNT_INIT;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          // LATENCY cycles in WAIT, so m_din is taken at the end of cycle LATENCY after the strobe
          if (cnt_q == 3'd0) begin
            if (owner_q == OWN_A) begin
              a_rdata_q <= bus.m_din;
            end
            if (owner_q == OWN_B) begin
              b_rdata_q <= bus.m_din;
            end
            a_ack_q <= (owner_q == OWN_A);
            b_ack_q <= (owner_q == OWN_B);
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end

        S_DONE: begin
`ifdef DATA_BUS_ARBITER_RR_EN
          last_q  <= owner_q[1];
`endif
          owner_q <= OWN_NONE;
          state_q <= S_IDLE;
        end

        default: begin
          owner_q <= OWN_NONE;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.m_strobe = strobe_q;
  assign bus.m_rw     = rw_q;
  assign bus.m_addr   = addr_q;
  assign bus.m_dout   = wdata_q;
  assign bus.a_ack    = a_ack_q;
  assign bus.b_ack    = b_ack_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.owner    = owner_q;

endmodule
